// File: rtl/vec_accum_pkg.sv
// Shared definitions for the vector accumulator: controller states and
// the default lane format.
package vec_accum_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 16;
    localparam     DEF_PRECISION = "Q8.8";

endpackage

// File: rtl/add_vec.sv
// Lane-wise signed vector adder. Each lane wraps independently; no carry
// crosses a lane boundary.
module add_vec
    import vec_accum_pkg::*;
#(
    parameter int DIM       = 1,
    parameter int WIDTH     = DEF_WIDTH,
    parameter     precision = DEF_PRECISION
) (
    input  logic [DIM*WIDTH-1:0] a,
    input  logic [DIM*WIDTH-1:0] b,
    output logic [DIM*WIDTH-1:0] sum
);

    function automatic logic signed [WIDTH-1:0] wrap_add(
        input logic signed [WIDTH-1:0] x,
        input logic signed [WIDTH-1:0] y
    );
        logic signed [WIDTH:0] full;
        full = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        return full[WIDTH-1:0];
    endfunction

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        logic signed [WIDTH-1:0] lane_a;
        logic signed [WIDTH-1:0] lane_b;
        assign lane_a = a[i*WIDTH +: WIDTH];
        assign lane_b = b[i*WIDTH +: WIDTH];
        assign sum[i*WIDTH +: WIDTH] = wrap_add(lane_a, lane_b);
    end

endmodule

// File: rtl/vec_accum.sv
// Vector accumulator: sums len input vectors lane by lane and presents the
// result on a valid/ready output until the consumer takes it.
module vec_accum
    import vec_accum_pkg::*;
#(
    parameter int DIM       = 1,
    parameter int WIDTH     = DEF_WIDTH,
    parameter     precision = DEF_PRECISION,
    parameter int MAX_LEN   = 16,
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LW-1:0]        len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIM*WIDTH-1:0] in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIM*WIDTH-1:0] out_vec,
    output logic                 busy
);

    state_t                 state, state_nxt;
    logic [DIM*WIDTH-1:0]   acc, acc_nxt;
    logic [DIM*WIDTH-1:0]   sum;
    logic [LW-1:0]          cnt, cnt_nxt;

    add_vec #(
        .DIM       (DIM),
        .WIDTH     (WIDTH),
        .precision (precision)
    ) u_add (
        .a   (acc),
        .b   (in_vec),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_nxt = '0;
                    if (len == '0) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        // Over-long requests are clamped to the capacity.
                        cnt_nxt   = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
                        state_nxt = ACC;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_nxt = sum;
                    cnt_nxt = cnt - LW'(1);
                    if (cnt == LW'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == ACC);
    assign out_valid = (state == DONE);
    assign out_vec   = out_valid ? acc : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_vec_accum.sv
// Directed bench for vec_accum with two 16-bit lanes.
module tb_vec_accum;

    localparam int DIM     = 2;
    localparam int WIDTH   = 16;
    localparam int MAX_LEN = 16;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [LW-1:0]        len;
    logic                 in_valid;
    logic                 in_ready;
    logic [DIM*WIDTH-1:0] in_vec;
    logic                 out_valid;
    logic                 out_ready;
    logic [DIM*WIDTH-1:0] out_vec;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    vec_accum #(
        .DIM       (DIM),
        .WIDTH     (WIDTH),
        .precision ("Q8.8"),
        .MAX_LEN   (MAX_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_vec = '0; out_ready = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_vec !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b vec=%h, want 0 0 0 0",
                     in_ready, out_valid, busy, out_vec);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [DIM*WIDTH-1:0] vecs [3];
        vecs[0] = {16'h0100, 16'h0100};
        vecs[1] = {16'h0200, 16'hFF00};
        vecs[2] = {16'h0300, 16'h0080};
        start = 1'b1; len = LW'(3);
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_ready%0d: rdy=%b vld=%b, want 1 0", i, in_ready, out_valid);
            end
            in_valid = 1'b1; in_vec = vecs[i];
            step();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== {16'h0600, 16'h0080} || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: vld=%b vec=%h rdy=%b, want 1 06000080 0",
                     out_valid, out_vec, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_vec !== '0) begin
            errors++;
            $display("FAIL basic_release: vld=%b busy=%b vec=%h, want 0 0 0",
                     out_valid, busy, out_vec);
        end
    endtask

    task automatic test_wrap();
        start = 1'b1; len = LW'(2);
        step();
        start = 1'b0; in_valid = 1'b1;
        in_vec = {16'h7F00, 16'h8000};
        step();
        in_vec = {16'h0200, 16'h8000};
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== {16'h8100, 16'h0000}) begin
            errors++;
            $display("FAIL wrap_sum: vld=%b vec=%h, want 1 81000000", out_valid, out_vec);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_gaps_backpressure();
        logic [DIM*WIDTH-1:0] held;
        start = 1'b1; len = LW'(2);
        step();
        start = 1'b0; in_valid = 1'b1; in_vec = {16'h0011, 16'hFFFF};
        step();
        in_valid = 1'b0; in_vec = {16'h1234, 16'h5678};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d: busy=%b rdy=%b vld=%b, want 1 1 0",
                         i, busy, in_ready, out_valid);
            end
        end
        in_valid = 1'b1; in_vec = {16'h0022, 16'h0003};
        step();
        in_valid = 1'b0;
        held = out_vec;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== {16'h0033, 16'h0002}) begin
            errors++;
            $display("FAIL gap_sum: vld=%b vec=%h, want 1 00330002", out_valid, out_vec);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out_vec !== held) begin
                errors++;
                $display("FAIL bp_stable%0d: vld=%b busy=%b vec=%h, want 1 1 %h",
                         i, out_valid, busy, out_vec, held);
            end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: busy=%b vld=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_len_zero();
        start = 1'b1; len = '0;
        step();
        start = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL len0_done: vld=%b vec=%h busy=%b, want 1 0 1", out_valid, out_vec, busy);
        end
        start = 1'b1; len = LW'(3);
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_start_ignored: vld=%b rdy=%b, want 1 0", out_valid, in_ready);
        end
        out_ready = 1'b1;
        step();
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL len0_handshake_start: busy=%b rdy=%b, want 0 0", busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; len = LW'(3);
        step();
        start = 1'b0; in_valid = 1'b1; in_vec = {16'h1111, 16'h2222};
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_vec !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: rdy=%b vld=%b busy=%b vec=%h, want 0 0 0 0",
                     in_ready, out_valid, busy, out_vec);
        end
        step();
        rst_n = 1'b1;
        start = 1'b1; len = LW'(1);
        step();
        start = 1'b0; in_valid = 1'b1; in_vec = {16'h0005, 16'h0007};
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_vec !== {16'h0005, 16'h0007}) begin
            errors++;
            $display("FAIL midrst_restart: vld=%b vec=%h, want 1 00050007", out_valid, out_vec);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_max_len();
        int n = 0;
        bit done = 1'b0;
        start = 1'b1; len = LW'(MAX_LEN + 1);
        step();
        start = 1'b0; in_valid = 1'b1; in_vec = {16'h0001, 16'h0002};
        for (int i = 0; i < 40 && !done; i++) begin
            if (in_ready) n++;
            step();
            if (out_valid) done = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done || n != MAX_LEN) begin
            errors++;
            $display("FAIL maxlen_count: done=%b transfers=%0d, want 1 %0d", done, n, MAX_LEN);
        end
        checks++;
        if (out_vec !== {16'h0010, 16'h0020}) begin
            errors++;
            $display("FAIL maxlen_sum: vec=%h, want 00100020", out_vec);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_gaps_backpressure();
        test_len_zero();
        test_reset_mid();
        test_max_len();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_accum.md
VEC_ACCUM -- requirements
Module: vec_accum

Interface
REQ-001 Parameter DIM, default 1: number of lanes per vector.
REQ-002 Parameter WIDTH, default 16: bits per lane, signed two's complement.
REQ-003 Parameter precision, default "Q8.8": fixed-point format label; informational only; no effect on arithmetic.
REQ-004 Parameter MAX_LEN, default 16: maximum vectors per accumulation; LW = $clog2(MAX_LEN+1).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Port clk  input  1  rising-edge clock.
REQ-007 Port rst_n  input  1  asynchronous active-low reset.
REQ-008 Port start  input  1  single-cycle request to begin an accumulation.
REQ-009 Port len  input  LW  number of vectors to accumulate; sampled with start.
REQ-010 Port in_valid  input  1  in_vec valid.
REQ-011 Port in_ready  output  1  block accepts in_vec.
REQ-012 Port in_vec  input  DIM*WIDTH  signed packed vector; lane i at [i*WIDTH +: WIDTH].
REQ-013 Port out_valid  output  1  out_vec holds the finished sum.
REQ-014 Port out_ready  input  1  consumer accepts out_vec.
REQ-015 Port out_vec  output  DIM*WIDTH  signed packed accumulated vector, same lane packing.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ACC and DONE.
REQ-018 In IDLE: in_ready=0, out_valid=0; start with len>=1 clears every accumulator lane to 0, loads cnt=min(len,MAX_LEN) and enters ACC next cycle.
REQ-019 In IDLE, start with len==0 clears the accumulator and enters DONE next cycle, emitting a zero vector.
REQ-020 start SHALL be ignored in ACC and DONE.
REQ-021 In ACC: in_ready=1; a transfer occurs when in_valid&&in_ready; per transfer, lane i <= lane i + in_vec lane i; cnt decrements.
REQ-022 Lane addition SHALL wrap modulo 2^WIDTH with no saturation and no carry between lanes.
REQ-023 The transfer with cnt==1 SHALL move the FSM to DONE; out_valid rises the next cycle (one-cycle latency from last input).
REQ-024 Cycles with in_valid=0 in ACC SHALL leave accumulator and cnt unchanged.
REQ-025 Throughput: one vector per cycle while in_valid stays high.
REQ-026 In DONE: out_valid=1, in_ready=0; out_vec=accumulator, held stable until out_valid&&out_ready, then IDLE next cycle.
REQ-027 out_vec SHALL be 0 whenever out_valid=0.
REQ-028 start and the out_valid&&out_ready handshake in the same cycle: start is ignored (FSM is in DONE); a new start is honoured only from IDLE.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, accumulator 0, cnt 0, in_ready=0, out_valid=0, out_vec=0, busy=0.
REQ-030 Reset asserted mid-ACC or mid-DONE SHALL discard the partial or pending sum; no output is produced for it.
REQ-031 After rst_n deassertion, the block SHALL act on the first start.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, ACC, DONE) and the default WIDTH and precision constants.
REQ-033 The per-lane accumulator update SHALL instantiate the existing add_vec (DIM, WIDTH, precision passed through), with a = accumulator and b = in_vec.
REQ-034 Accumulator, cnt and state SHALL be the only registers; all outputs are derived from them.

Verification (DIM=2, WIDTH=16)
REQ-035 start, len=3; in_vec {0x0100,0x0100}, {0x0200,0xFF00}, {0x0300,0x0080} back-to-back -> out_valid one cycle after the third transfer, out_vec {0x0600,0x0080}.
REQ-036 Wrap: len=2; {0x7F00,0x8000} then {0x0200,0x8000} -> out_vec {0x8100,0x0000}.
REQ-037 Backpressure and gaps: len=2 with in_valid low for 3 cycles between the two inputs, then out_ready low for 5 cycles -> sum correct; out_vec stable; busy high throughout; IDLE one cycle after out_ready rises.
REQ-038 len=0 -> out_valid the next cycle with out_vec 0; start pulsed during DONE -> ignored.
REQ-039 rst_n low after 1 of 3 inputs -> all outputs 0 immediately; a new start with len=1 and input {0x0005,0x0007} -> out_vec {0x0005,0x0007}.
REQ-040 len=MAX_LEN+1 (e.g. 17) -> exactly 16 transfers accepted before DONE.
